store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//  Posted-store buffer sitting directly upstream of the data memory.
//  Queues core stores and drains them into the memory's single write/read port when no load uses it.
//  Forwards the newest buffered data to loads that hit a pending store.
//  Lets the core retire a store without owning the memory port that cycle.
// PARAMETERS
//  DEPTH  4   number of buffered stores (power of 2, >=2)
//  AW     32  address width (word index, used directly as memory A)
//  DW     32  data width
// PORTS
//  clk         in   1      single clock, all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  st_valid    in   1      core store request
//  st_addr     in   AW     store address
//  st_data     in   DW     store data
//  st_ready    out  1      store accepted this cycle (core stalls when 0)
//  ld_valid    in   1      core load request (owns memory port this cycle)
//  ld_addr     in   AW     load address
//  ld_data     out  DW     load result (forwarded or from memory), combinational
//  ld_fwd      out  1      ld_data came from buffer
//  flush       in   1      request full drain (level, sampled in RUN)
//  flush_done  out  1      one-cycle pulse when a flush completes
//  mem_we      out  1      memory write enable
//  mem_a       out  AW     memory address
//  mem_wd      out  DW     memory write data
//  mem_rd      in   DW     memory async read data
//  empty       out  1      no pending stores
//  count       out  log2(DEPTH)+1  pending store count
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0, all entry valid bits cleared, state=RUN.
//  Reset outputs: mem_we=0, st_ready=1, empty=1, flush_done=0.
//  Reset mid-operation discards pending stores; memory is not written.
//  Storage: circular FIFO of {addr,data,valid}; pointers wrap modulo DEPTH.
//  st_ready = (count<DEPTH) && state==RUN; uses current count only.
//   A pop in the same cycle does not enable a push into a full buffer.
//  Push: st_valid&&st_ready -> entry[wr_ptr] written at posedge; wr_ptr++.
//  Port mux, combinational:
//   ld_valid=1 -> mem_a=ld_addr, mem_we=0 (load priority; drain stalls).
//   else if !empty -> mem_a=head.addr, mem_wd=head.data, mem_we=1.
//   Pop at the posedge of the same cycle; rd_ptr++, head valid cleared.
//   else mem_we=0, mem_a=0, mem_wd=0.
//  Push+pop same cycle: count unchanged; both pointers advance.
//  Drain latency: an accepted store reaches memory no earlier than the next cycle.
//   Memory is written at the posedge ending the first load-free cycle with it at head.
//  Forwarding: ld_fwd=1 if any valid entry addr==ld_addr (full AW compare).
//   ld_data = data of newest matching entry (nearest behind wr_ptr), else mem_rd.
//   Duplicate addresses are allowed; memory ends with the last store's value (FIFO order).
//  st_valid && ld_valid in the same cycle: store accepted if st_ready.
//   The load sees buffer state before that push (no same-cycle forward).
//  FSM: RUN --(flush)--> FLUSH; FLUSH --(count==0, no pop pending)--> RUN.
//   flush_done=1 on the FLUSH->RUN transition cycle only.
//   flush with empty buffer: enter FLUSH, pulse flush_done next cycle, return to RUN.
//   Loads and forwarding stay active in FLUSH; st_ready=0 throughout FLUSH.
//  empty=(count==0); count is a registered value.
// TESTING
//  1. Reset, then store A=5 D=0xAAAA, ld_valid=0 -> cycle+1: mem_we=1, mem_a=5, mem_wd=0xAAAA; cycle+2: empty=1.
//  2. Hold ld_valid=1 continuously; 4 stores (DEPTH=4) -> st_ready=0 on 5th; count=4.
//     Release ld_valid -> 4 drains in order, one per cycle.
//  3. Stores A=7 D=1 then A=7 D=2 with drain blocked; load A=7 -> ld_fwd=1, ld_data=2.
//     Load A=8 -> ld_fwd=0, ld_data=mem_rd.
//  4. Full buffer: st_valid and drain in the same cycle -> store not accepted, count 4->3; next cycle store accepted.
//  5. 3 pending stores, pulse flush -> st_ready=0 until drained.
//     flush_done pulses exactly once after the 3rd write; then st_ready=1.
//  6. 2 pending stores, assert rst one cycle -> mem_we=0, count=0, empty=1, no memory writes follow.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: core store/load, flush and memory-port signals of the store write buffer
interface store_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic st_ready;
  logic ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic ld_fwd;
  logic flush;
  logic flush_done;
  logic mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic empty;
  logic [CW-1:0] count;
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_rd,
    input st_ready, ld_data, ld_fwd, flush_done, mem_we, mem_a, mem_wd, empty, count
  );
  modport slave (
    input st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_rd,
    output st_ready, ld_data, ld_fwd, flush_done, mem_we, mem_a, mem_wd, empty, count
  );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO draining into a shared memory port with load forwarding
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [AW-1:0] e_addr [DEPTH];
  logic [DW-1:0] e_data [DEPTH];
  logic [DEPTH-1:0] e_valid;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic push, pop, empty_i;
  assign empty_i = cnt == '0;
  assign bus.empty = empty_i;
  assign bus.count = cnt;
  assign bus.st_ready = cnt < CW'(DEPTH) && state == RUN;
  assign push = bus.st_valid && bus.st_ready;
  // Reset gates the drain so a reset cycle never writes a discarded store
  assign pop = !rst && !bus.ld_valid && !empty_i;
  assign bus.mem_we = pop;
  assign bus.mem_a = bus.ld_valid ? bus.ld_addr : pop ? e_addr[rd_ptr] : '0;
  assign bus.mem_wd = pop ? e_data[rd_ptr] : '0;
  // Scan oldest to newest so the youngest matching entry wins
  always_comb begin
    bus.ld_fwd = 1'b0;
    bus.ld_data = bus.mem_rd;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid[rd_ptr + PW'(i)] && e_addr[rd_ptr + PW'(i)] == bus.ld_addr) begin
        bus.ld_fwd = 1'b1;
        bus.ld_data = e_data[rd_ptr + PW'(i)];
      end
    end
  end
  always_comb begin
    state_nx = state == RUN ? (bus.flush ? FLUSH : RUN) : (empty_i ? RUN : FLUSH);
    bus.flush_done = state == FLUSH && empty_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      e_valid <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        e_addr[wr_ptr] <= bus.st_addr;
        e_data[wr_ptr] <= bus.st_data;
        e_valid[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        e_valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed and random stimulus against a queue-based store buffer model
module tb_store_write_buffer;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  store_write_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) bus ();
  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] tb_mem [16] = '{default: 0};
  logic [31:0] ref_mem [16] = '{default: 0};
  assign bus.mem_rd = tb_mem[bus.mem_a[3:0]];
  always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_a[3:0]] <= bus.mem_wd;
  ent_t pend[$];
  ent_t exp_wr[$];
  logic [32:0] exp_ld[$];
  logic m_fl = 0;
  logic chk_en = 0, in_rst = 0;
  logic exp_we, exp_ready, exp_empty, exp_done;
  logic [2:0] exp_count;
  int total = 0, bad = 0;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endfunction
  ent_t me;
  logic [32:0] ml;
  always @(negedge clk) if (chk_en) begin
    chk("mem_we", bus.mem_we, exp_we);
    if (!in_rst) begin
      chk("st_ready", bus.st_ready, exp_ready);
      chk("count", bus.count, exp_count);
      chk("empty", bus.empty, exp_empty);
      chk("flush_done", bus.flush_done, exp_done);
    end
    if (bus.mem_we) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", bus.mem_a, bus.mem_wd);
      end else begin
        me = exp_wr.pop_front();
        chk("mem_a", bus.mem_a, me.a);
        chk("mem_wd", bus.mem_wd, me.d);
      end
    end
    if (bus.ld_valid && !in_rst) begin
      if (exp_ld.size() == 0) begin
        total++; bad++;
        $display("FAIL load_unexpected actual=%0h required=none", bus.ld_data);
      end else begin
        ml = exp_ld.pop_front();
        chk("ld_fwd", bus.ld_fwd, ml[32]);
        chk("ld_data", bus.ld_data, ml[31:0]);
      end
    end
  end
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la, input logic fl, input logic r);
    logic fwd;
    logic [31:0] d;
    @(posedge clk); #1;
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
    bus.ld_valid = lv; bus.ld_addr = la; bus.flush = fl;
    rst = r; in_rst = r;
    if (r) begin
      exp_we = 0;
      pend.delete(); exp_wr.delete(); exp_ld.delete();
      m_fl = 0;
    end else begin
      exp_ready = pend.size() < 4 && !m_fl;
      exp_count = 3'(pend.size());
      exp_empty = pend.size() == 0;
      exp_done = m_fl && pend.size() == 0;
      exp_we = !lv && pend.size() > 0;
      if (lv) begin
        fwd = 0;
        d = ref_mem[la[3:0]];
        foreach (pend[i]) if (pend[i].a == la) begin fwd = 1; d = pend[i].d; end
        exp_ld.push_back({fwd, d});
      end
      if (!m_fl) m_fl = fl;
      else if (pend.size() == 0) m_fl = 0;
      if (exp_we) begin
        ref_mem[pend[0].a[3:0]] = pend[0].d;
        void'(pend.pop_front());
      end
      if (sv && exp_ready) begin
        pend.push_back('{sa, sd});
        exp_wr.push_back('{sa, sd});
      end
    end
    chk_en = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.flush = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 5, 32'hAAAA, 0, 0, 0, 0);
    idle(3);
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 32'h100 + 32'(i), 1, 9, 0, 0);
    idle(6);
    step(1, 7, 1, 1, 9, 0, 0);
    step(1, 7, 2, 1, 9, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 8, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(10 + i), 32'h200 + 32'(i), 1, 1, 0, 0);
    step(1, 3, 32'h44, 0, 0, 0, 0);
    step(1, 3, 32'h45, 0, 0, 0, 0);
    idle(6);
    for (int i = 0; i < 3; i++) step(1, 32'(i), 32'h300 + 32'(i), 1, 2, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 6, 32'h400 + 32'(i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    step(1, 4, 32'h51, 1, 0, 0, 0);
    step(1, 5, 32'h52, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 4, 32'($urandom_range(0, 7)),
           $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    idle(10);
    @(posedge clk); #1;
    chk_en = 0;
    chk("final_pending", 64'(exp_wr.size()), 0);
    for (int i = 0; i < 16; i++) chk("mem_image", tb_mem[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
